sdram_frame_arbiter: RTL and testbench

//  Shares the single-port frame memory between the camera write path and the VGA read path.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_frame_arbiter_if.sv | 15 +
 rtl/frame_addr_gen.sv | 46 ++++
 rtl/sdram_frame_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default geometry for the frame-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } arb_state_t;

  localparam int DEF_BURST       = 256;
  localparam int DEF_FRAME_WORDS = 307200;
  localparam int PTR_W           = $clog2(DEF_FRAME_WORDS);
  localparam int FRAME_BURSTS    = DEF_FRAME_WORDS / DEF_BURST;

endpackage

// File: rtl/sdram_frame_arbiter_if.sv
// Burst command channel between the frame arbiter and the memory controller.
// Latency: n/a (wires only).
// Backpressure: request is held by the master until the slave pulses mem_ack.
interface sdram_frame_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_done;

  modport master (output mem_req, mem_wr, mem_addr, input mem_ack, mem_done);
  modport slave  (input mem_req, mem_wr, mem_addr, output mem_ack, mem_done);
endinterface

// File: rtl/frame_addr_gen.sv
// Frame pointer for one direction: steps per finished burst, wraps at frame end, resyncs on vsync.
// Latency: cur_ptr already reflects a sync that can be applied this cycle.
// Backpressure: a sync arriving mid-burst is held pending until that burst's done.
module frame_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int BURST       = DEF_BURST,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int PW          = PTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sync,     // one-cycle frame sync edge
  input  logic          active,   // FSM is in REQ/BUSY for this direction
  input  logic          done,     // burst of this direction completed
  output logic [PW-1:0] cur_ptr,  // pointer the next request must use
  output logic          wrap,     // last burst of the frame completed
  output logic          apply     // pending sync is being applied
);
  localparam logic [PW-1:0] STEP = PW'(BURST);
  localparam logic [PW-1:0] LAST = PW'(FRAME_WORDS - BURST);

  logic [PW-1:0] ptr;
  logic          pend;
  logic          pend_now;

  // A sync seen this very cycle counts as pending so an idle FSM picks it up at once.
  assign pend_now = pend | sync;
  assign apply    = pend_now & (~active | done);
  assign wrap     = done & (ptr == LAST);
  assign cur_ptr  = (pend_now & ~active) ? '0 : ptr;

  // Pointer advance/wrap and sync bookkeeping; a sync never disturbs a burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      pend <= 1'b0;
    end else if (apply) begin
      ptr  <= '0;
      pend <= 1'b0;
    end else begin
      if (done) ptr <= wrap ? '0 : ptr + STEP;
      if (sync) pend <= 1'b1;
    end
  end
endmodule

// File: rtl/sdram_frame_arbiter.sv
// Arbitrates single-port frame memory between camera writes and VGA reads, one burst at a time.
// Latency: eligible FIFO level in IDLE -> mem_req one cycle later; one IDLE cycle between bursts.
// Backpressure: mem_req/mem_wr/mem_addr held until mem_ack; next decision only after mem_done.
// Build option: define SDRAM_ARB_PINGPONG_EN for two-bank (tear-free) frame buffering.
module sdram_frame_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 22,
  parameter int FIFO_W      = 10,
  parameter int BURST       = DEF_BURST,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int RD_LOW      = 128,
  parameter int RD_HIGH     = 768,
  parameter int BANK_OFS    = 524288
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cam_vsync,
  input  logic                  vga_vys,
  input  logic [FIFO_W-1:0]     wr_usedw,
  input  logic [FIFO_W-1:0]     rd_usedw,
  sdram_frame_arbiter_if.master mem,
  output logic                  rd_underrun
);
  localparam int                PW        = $clog2(FRAME_WORDS);
  localparam logic [FIFO_W-1:0] LOW_LVL   = FIFO_W'(RD_LOW);
  localparam logic [FIFO_W-1:0] HIGH_LVL  = FIFO_W'(RD_HIGH);
  localparam logic [FIFO_W-1:0] BURST_LVL = FIFO_W'(BURST);

  arb_state_t        state;
  logic              last_wr;
  logic              cam_q, vys_q;
  logic              cam_rise, vys_fall;
  logic              rd_urgent, rd_ok, wr_ok;
  logic              grant, sel_wr;
  logic              wr_active, rd_active, wr_done, rd_done;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              wr_wrap, rd_wrap, wr_apply, rd_apply;
  logic [ADDR_W-1:0] wr_base, rd_base, req_addr;
  logic              unused_flags;

  assign cam_rise  = cam_vsync & ~cam_q;
  assign vys_fall  = ~vga_vys & vys_q;
  assign rd_urgent = rd_usedw < LOW_LVL;
  assign rd_ok     = rd_usedw < HIGH_LVL;
  assign wr_ok     = wr_usedw >= BURST_LVL;
  assign wr_active = (state != IDLE) & mem.mem_wr;
  assign rd_active = (state != IDLE) & ~mem.mem_wr;
  assign wr_done   = mem.mem_done & (state == BUSY) & mem.mem_wr;
  assign rd_done   = mem.mem_done & (state == BUSY) & ~mem.mem_wr;
  assign req_addr  = sel_wr ? wr_base + ADDR_W'(wr_ptr) : rd_base + ADDR_W'(rd_ptr);

  // Sync edge detectors; vys idles high so its history resets high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_q <= 1'b0;
      vys_q <= 1'b1;
    end else begin
      cam_q <= cam_vsync;
      vys_q <= vga_vys;
    end
  end

  // Priority: urgent read, then alternate when both eligible, then whichever side is eligible.
  always_comb begin
    grant  = 1'b0;
    sel_wr = 1'b0;
    if (rd_urgent) begin
      grant = 1'b1;
    end else if (wr_ok && rd_ok) begin
      grant  = 1'b1;
      sel_wr = ~last_wr;
    end else if (wr_ok) begin
      grant  = 1'b1;
      sel_wr = 1'b1;
    end else if (rd_ok) begin
      grant = 1'b1;
    end
  end

  // Burst command FSM; command fields are captured on entry to REQ and held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem.mem_req  <= 1'b0;
      mem.mem_wr   <= 1'b0;
      mem.mem_addr <= '0;
      last_wr      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state        <= REQ;
          mem.mem_req  <= 1'b1;
          mem.mem_wr   <= sel_wr;
          mem.mem_addr <= req_addr;
          last_wr      <= sel_wr;
        end
        REQ: if (mem.mem_ack) begin
          state       <= BUSY;
          mem.mem_req <= 1'b0;
        end
        BUSY: if (mem.mem_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  frame_addr_gen #(.BURST(BURST), .FRAME_WORDS(FRAME_WORDS), .PW(PW)) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .sync(cam_rise), .active(wr_active), .done(wr_done),
    .cur_ptr(wr_ptr), .wrap(wr_wrap), .apply(wr_apply)
  );

  frame_addr_gen #(.BURST(BURST), .FRAME_WORDS(FRAME_WORDS), .PW(PW)) u_rd_gen (
    .clk(clk), .rst_n(rst_n), .sync(vys_fall), .active(rd_active), .done(rd_done),
    .cur_ptr(rd_ptr), .wrap(rd_wrap), .apply(rd_apply)
  );

  // Underrun is sticky for the whole VGA frame; the frame-start resync clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_underrun <= 1'b0;
    end else if (rd_apply) begin
      rd_underrun <= 1'b0;
    end else if (rd_usedw == '0 && vga_vys && rd_ptr != '0) begin
      rd_underrun <= 1'b1;
    end
  end

`ifdef SDRAM_ARB_PINGPONG_EN
  logic wr_bank, rd_bank, ready_bank, frame_done;

  // Publish each completed frame; the writer only moves into a bank the reader is not holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      ready_bank <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (wr_wrap) ready_bank <= wr_bank;
      if (wr_apply) begin
        frame_done <= 1'b0;
        if ((frame_done | wr_wrap) && (~wr_bank != rd_bank)) wr_bank <= ~wr_bank;
      end else if (wr_wrap) begin
        frame_done <= 1'b1;
      end
      if (rd_apply) rd_bank <= ready_bank;
    end
  end

  assign wr_base      = wr_bank ? ADDR_W'(BANK_OFS) : '0;
  assign rd_base      = rd_bank ? ADDR_W'(BANK_OFS) : '0;
  assign unused_flags = rd_wrap;
`else
  // Single shared bank: reader and writer may tear against each other.
  assign wr_base      = '0;
  assign rd_base      = '0;
  assign unused_flags = ^{rd_wrap, wr_wrap, wr_apply, 32'(BANK_OFS)};
`endif
endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for the frame-memory arbiter, acting as the memory controller by hand.
// Latency: n/a.
// Backpressure: the bench accepts each request one cycle after it appears.
module tb_sdram_frame_arbiter;
  import sdram_arb_pkg::*;

`ifdef SDRAM_ARB_PINGPONG_EN
  localparam logic [31:0] BANK1        = 32'd524288;
  localparam logic [31:0] WR_SYNC_ADDR = 32'd524288;
`else
  localparam logic [31:0] WR_SYNC_ADDR = 32'd0;
`endif

  logic       clk;
  logic       rst_n;
  logic       cam_vsync;
  logic       vga_vys;
  logic [9:0] wr_usedw;
  logic [9:0] rd_usedw;
  logic       rd_underrun;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  sdram_frame_arbiter_if #(.ADDR_W(22)) mem_if ();

  sdram_frame_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .vga_vys(vga_vys),
    .wr_usedw(wr_usedw), .rd_usedw(rd_usedw), .mem(mem_if), .rd_underrun(rd_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a request, capture it, and accept it.
  task automatic grab(output logic w, output logic [21:0] a, output bit ok);
    int n = 0;
    while (mem_if.mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = (mem_if.mem_req === 1'b1);
    w  = mem_if.mem_wr;
    a  = mem_if.mem_addr;
    if (ok) begin
      mem_if.mem_ack = 1'b1;
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
    end
  endtask

  task automatic finish_burst();
    mem_if.mem_done = 1'b1;
    @(negedge clk);
    mem_if.mem_done = 1'b0;
  endtask

  task automatic expect_burst(input string tag, input logic [31:0] exp_wr, input logic [31:0] exp_addr);
    logic        w;
    logic [21:0] a;
    bit          ok;
    grab(w, a, ok);
    check_val({tag, "_req"}, 32'(ok), 32'd1);
    check_val({tag, "_wr"}, 32'(w), exp_wr);
    check_val({tag, "_addr"}, 32'(a), exp_addr);
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (mem_if.mem_req === 1'b1) seen++;
    end
    check_val(tag, 32'(seen), 32'd0);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    cam_vsync       = 1'b0;
    vga_vys         = 1'b1;
    wr_usedw        = 10'd0;
    rd_usedw        = 10'd768;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full frame of write bursts starting at base; reports address errors and the first address.
  task automatic write_frame(input logic [21:0] base, output int bad, output logic [21:0] first);
    logic        w;
    logic [21:0] a;
    bit          ok;
    bad      = 0;
    first    = '1;
    wr_usedw = 10'd300;
    for (int i = 0; i < FRAME_BURSTS; i++) begin
      grab(w, a, ok);
      if (!ok) begin
        bad++;
        break;
      end
      if (i == 0) first = a;
      if (w !== 1'b1 || a !== base + 22'(i * 256)) bad++;
      if (i == FRAME_BURSTS - 1) wr_usedw = 10'd0;
      finish_burst();
    end
    wr_usedw = 10'd0;
  endtask

  task automatic pulse_cam();
    cam_vsync = 1'b1;
    @(negedge clk);
    cam_vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_vys();
    vga_vys = 1'b0;
    repeat (2) @(negedge clk);
    vga_vys = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int          bad;
    logic [21:0] first;

    // Reset values while reset is held.
    rst_n = 1'b0; cam_vsync = 1'b0; vga_vys = 1'b1;
    wr_usedw = 10'd0; rd_usedw = 10'd768;
    mem_if.mem_ack = 1'b0; mem_if.mem_done = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_req", 32'(mem_if.mem_req), 32'd0);
    check_val("rst_wr", 32'(mem_if.mem_wr), 32'd0);
    check_val("rst_addr", 32'(mem_if.mem_addr), 32'd0);
    check_val("rst_underrun", 32'(rd_underrun), 32'd0);
    rst_n = 1'b1;
    expect_idle("idle_after_rst", 6);

    // Reset in the middle of a burst.
    wr_usedw = 10'd300;
    expect_burst("t1_wr0", 32'd1, 32'd0);
    finish_burst();
    expect_burst("t1_wr1", 32'd1, 32'd256);
    rst_n = 1'b0;
    wr_usedw = 10'd0;
    @(negedge clk);
    check_val("rst_busy_req", 32'(mem_if.mem_req), 32'd0);
    check_val("rst_busy_wr", 32'(mem_if.mem_wr), 32'd0);
    check_val("rst_busy_addr", 32'(mem_if.mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("no_spurious", 8);
    wr_usedw = 10'd300;
    expect_burst("t1_ptr_cleared", 32'd1, 32'd0);
    wr_usedw = 10'd0;
    finish_burst();

    // Arbitration order and FIFO-level boundaries.
    do_reset();
    rd_usedw = 10'd100; wr_usedw = 10'd300;
    expect_burst("urgent_rd", 32'd0, 32'd0);
    rd_usedw = 10'd500;
    finish_burst();
    expect_burst("alt_wr", 32'd1, 32'd0);
    finish_burst();
    expect_burst("alt_rd", 32'd0, 32'd256);
    rd_usedw = 10'd127;
    finish_burst();
    expect_burst("low_bound_rd", 32'd0, 32'd512);
    rd_usedw = 10'd128;
    finish_burst();
    expect_burst("low_edge_wr", 32'd1, 32'd256);
    rd_usedw = 10'd767; wr_usedw = 10'd255;
    finish_burst();
    expect_burst("high_edge_rd", 32'd0, 32'd768);
    rd_usedw = 10'd768;
    finish_burst();
    expect_idle("high_idle", 6);
    wr_usedw = 10'd256;
    expect_burst("burst_edge_wr", 32'd1, 32'd512);
    wr_usedw = 10'd0;
    finish_burst();

    // One-cycle empty read FIFO mid-frame.
    rd_usedw = 10'd0;
    @(negedge clk);
    rd_usedw = 10'd768;
    check_val("underrun_set", 32'(rd_underrun), 32'd1);
    expect_burst("underrun_rd", 32'd0, 32'd1024);
    finish_burst();
    expect_idle("post_underrun_idle", 4);
    check_val("underrun_sticky", 32'(rd_underrun), 32'd1);

    // VGA sync during a read burst.
    rd_usedw = 10'd500;
    expect_burst("sync_rd", 32'd0, 32'd1280);
    rd_usedw = 10'd768;
    vga_vys = 1'b0;
    repeat (3) @(negedge clk);
    vga_vys = 1'b1;
    check_val("underrun_hold", 32'(rd_underrun), 32'd1);
    finish_burst();
    check_val("underrun_clr", 32'(rd_underrun), 32'd0);
    rd_usedw = 10'd500;
    expect_burst("sync_rd_addr", 32'd0, 32'd0);
    rd_usedw = 10'd768;
    finish_burst();

    // Full write frame and wrap, then camera resync.
    do_reset();
    write_frame(22'd0, bad, first);
    check_val("frame_addr_errs", 32'(bad), 32'd0);
    check_val("frame_first", 32'(first), 32'd0);
    wr_usedw = 10'd300;
    expect_burst("wr_wrap", 32'd1, 32'd0);
    wr_usedw = 10'd0;
    finish_burst();
    pulse_cam();
    wr_usedw = 10'd300;
    expect_burst("cam_sync", 32'd1, WR_SYNC_ADDR);
    wr_usedw = 10'd0;
    finish_burst();

`ifdef SDRAM_ARB_PINGPONG_EN
    // Two-bank hand-off between writer and reader.
    do_reset();
    write_frame(22'd0, bad, first);
    check_val("pp_f1_errs", 32'(bad), 32'd0);
    pulse_cam();
    pulse_vys();
    rd_usedw = 10'd500;
    expect_burst("pp_rd_bank0", 32'd0, 32'd0);
    rd_usedw = 10'd768;
    finish_burst();
    write_frame(22'(BANK1), bad, first);
    check_val("pp_f2_errs", 32'(bad), 32'd0);
    check_val("pp_wr_bank1", 32'(first), BANK1);
    pulse_vys();
    pulse_cam();
    rd_usedw = 10'd500;
    expect_burst("pp_rd_bank1", 32'd0, BANK1);
    rd_usedw = 10'd768;
    finish_burst();
    write_frame(22'd0, bad, first);
    check_val("pp_f3_errs", 32'(bad), 32'd0);
    check_val("pp_rewrite_bank0", 32'(first), 32'd0);
    pulse_cam();
    wr_usedw = 10'd300;
    expect_burst("pp_drop_frame", 32'd1, 32'd0);
    wr_usedw = 10'd0;
    finish_burst();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
